load_store_unit: RTL

Memory-stage load/store unit between the execute stage and the 256 x 16 data RAM. Accepts one load or store request through a valid/ready handshake, sequences the RAM's `mem_read`/`mem_write` strobes, and captures load data. Returns load results to writeback through a second valid/ready handshake. Optionally supports byte access, with read-modify-write for byte stores.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_byte_lane.sv | 28 ++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared widths, FSM state encoding and registered-request layout for the load/store unit.
package lsu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic              write;
        logic              byte_acc;
        logic              hi;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } lsu_req_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper: load lane extract with sign/zero extension and store lane merge.
module lsu_byte_lane #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] rd_word_i,
    input  logic              hi_i,
    input  logic              sgn_i,
    output logic [DATA_W-1:0] load_o,
    input  logic [DATA_W-1:0] merge_word_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0] lane;

    always_comb begin
        lane   = hi_i ? rd_word_i[15:8] : rd_word_i[7:0];
        load_o = {{(DATA_W-8){sgn_i & lane[7]}}, lane};

        merge_o = merge_word_i;
        if (hi_i) begin
            merge_o[15:8] = byte_i;
        end else begin
            merge_o[7:0]  = byte_i;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit sequencing a 256 x 16 RAM through a one-request-at-a-time FSM.
// Byte access with read-modify-write stores is enabled by defining LSU_BYTE_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = lsu_pkg::ADDR_W,
    parameter int unsigned DATA_W = lsu_pkg::DATA_W,
    parameter int unsigned TAG_W  = lsu_pkg::TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_hi,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] load_data;
    logic              unused_req_bits;

`ifdef LSU_BYTE_EN
    logic [DATA_W-1:0] rmw_q, rmw_d;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merge;

    lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .rd_word_i    (mem_read_data),
        .hi_i         (req_q.hi),
        .sgn_i        (req_q.sgn),
        .load_o       (lane_load),
        .merge_word_i (rmw_q),
        .byte_i       (req_q.wdata[7:0]),
        .merge_o      (lane_merge)
    );

    assign load_data       = req_q.byte_acc ? lane_load : mem_read_data;
    assign unused_req_bits = req_q.write;
`else
    assign load_data       = mem_read_data;
    assign unused_req_bits = ^{req_q.write, req_q.byte_acc, req_q.hi, req_q.sgn,
                               req_byte, req_hi, req_signed};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef LSU_BYTE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmw_q <= '0;
        end else begin
            rmw_q <= rmw_d;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        rsp_data_d     = rsp_data_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
`ifdef LSU_BYTE_EN
        rmw_d          = rmw_q;
`endif

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.tag   = req_tag;
`ifdef LSU_BYTE_EN
                    req_d.byte_acc = req_byte;
                    req_d.hi       = req_hi;
                    req_d.sgn      = req_signed;
                    if (req_write) begin
                        state_d = req_byte ? ST_RMW_RD : ST_STORE;
                    end else begin
                        state_d = ST_LOAD;
                    end
`else
                    req_d.byte_acc = 1'b0;
                    req_d.hi       = 1'b0;
                    req_d.sgn      = 1'b0;
                    state_d        = req_write ? ST_STORE : ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                mem_read   = 1'b1;
                rsp_data_d = load_data;
                state_d    = ST_RESP;
            end
            ST_STORE: begin
                mem_write      = 1'b1;
                mem_write_data = req_q.wdata;
                state_d        = ST_IDLE;
            end
`ifdef LSU_BYTE_EN
            ST_RMW_RD: begin
                mem_read = 1'b1;
                rmw_d    = mem_read_data;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write      = 1'b1;
                mem_write_data = lane_merge;
                state_d        = ST_IDLE;
            end
`endif
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag comes straight from the request register, which only changes in IDLE.
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = req_q.tag;
    assign mem_address = req_q.addr;

endmodule
